// File: rtl/ram_dp_arbiter_if.sv
// Bundle of client-side request/grant signals and RAM-side port signals for ram_dp_arbiter.
// slave: arbiter view; master: client + RAM view.
interface ram_dp_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic [1:0]        wr_req;
  logic [ADDR_W-1:0] wr_addr0;
  logic [ADDR_W-1:0] wr_addr1;
  logic [DATA_W-1:0] wr_data0;
  logic [DATA_W-1:0] wr_data1;
  logic [1:0]        wr_gnt;
  logic [1:0]        rd_req;
  logic [ADDR_W-1:0] rd_addr0;
  logic [ADDR_W-1:0] rd_addr1;
  logic [1:0]        rd_gnt;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        rd_valid;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_write_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic [ADDR_W-1:0] ram_read_addr;
  logic [DATA_W-1:0] ram_data_out;

  modport slave (
    input  wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
    input  rd_req, rd_addr0, rd_addr1, ram_data_out,
    output wr_gnt, rd_gnt, rd_data, rd_valid,
    output ram_we, ram_write_addr, ram_data_in, ram_read_addr
  );

  modport master (
    output wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
    output rd_req, rd_addr0, rd_addr1, ram_data_out,
    input  wr_gnt, rd_gnt, rd_data, rd_valid,
    input  ram_we, ram_write_addr, ram_data_in, ram_read_addr
  );
endinterface

// File: rtl/ram_dp_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM between two writers and two readers, with read-return tagging.
// Optional macro RAM_ARB_RAW_STALL_EN: stall a read that collides with the same-cycle write address.
module ram_dp_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int RD_LAT = 2
) (
  input logic            clk,
  input logic            rst,
  ram_dp_arbiter_if.slave bus
);

  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] gnt;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

  logic              wr_last;
  logic              rd_last;
  logic [1:0]        wr_gnt_c;
  logic [1:0]        rd_pick;
  logic [1:0]        rd_gnt_c;
  logic              raw_hit;
  logic [ADDR_W-1:0] wr_addr_sel;
  logic [ADDR_W-1:0] rd_addr_sel;
  logic [ADDR_W-1:0] rd_addr_hold;
  logic [RD_LAT-1:0] tag_vld_p;
  logic [RD_LAT-1:0] tag_id_p;

  always_comb begin
    wr_gnt_c    = rst ? 2'b00 : rr_pick(bus.wr_req, wr_last);
    rd_pick     = rst ? 2'b00 : rr_pick(bus.rd_req, rd_last);
    wr_addr_sel = wr_gnt_c[1] ? bus.wr_addr1 : bus.wr_addr0;
    rd_addr_sel = rd_pick[1] ? bus.rd_addr1 : bus.rd_addr0;
`ifdef RAM_ARB_RAW_STALL_EN
    // Withholding the whole read port keeps return order trivially in issue order.
    raw_hit     = (|wr_gnt_c) && (|rd_pick) && (rd_addr_sel == wr_addr_sel);
`else
    raw_hit     = 1'b0;
`endif
    rd_gnt_c    = raw_hit ? 2'b00 : rd_pick;
  end

  assign bus.wr_gnt         = wr_gnt_c;
  assign bus.ram_we         = |wr_gnt_c;
  assign bus.ram_write_addr = wr_addr_sel;
  assign bus.ram_data_in    = wr_gnt_c[1] ? bus.wr_data1 : bus.wr_data0;
  assign bus.rd_gnt         = rd_gnt_c;
  assign bus.ram_read_addr  = (|rd_gnt_c) ? rd_addr_sel : rd_addr_hold;
  assign bus.rd_data        = bus.ram_data_out;

  // Pointers move only on a grant so idle cycles leave fairness untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_last <= 1'b1;
      rd_last <= 1'b1;
    end else begin
      if (|wr_gnt_c) wr_last <= wr_gnt_c[1];
      if (|rd_gnt_c) rd_last <= rd_gnt_c[1];
    end
  end

  always_ff @(posedge clk) begin
    rd_addr_hold <= bus.ram_read_addr;
  end

  // Tag pipeline stage boundary: one {valid,id} entry per RAM read-latency cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_p <= '0;
    end else begin
      tag_vld_p[0] <= |rd_gnt_c;
      for (int i = 1; i < RD_LAT; i++) tag_vld_p[i] <= tag_vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_id_p[0] <= rd_gnt_c[1];
    for (int i = 1; i < RD_LAT; i++) tag_id_p[i] <= tag_id_p[i-1];
  end

  assign bus.rd_valid = tag_vld_p[RD_LAT-1] ? (tag_id_p[RD_LAT-1] ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_ram_dp_arbiter.sv
// Self-checking bench for ram_dp_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Honours RAM_ARB_RAW_STALL_EN when defined.
module tb_ram_dp_arbiter;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_dp_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  ram_dp_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // External RAM: address sampled at the edge, data two cycles later, read-old on collision.
  logic [DATA_W-1:0] ram_mem [64];
  logic [DATA_W-1:0] ram_pipe;
  always @(posedge clk) begin
    ram_pipe         <= ram_mem[bus.ram_read_addr];
    bus.ram_data_out <= ram_pipe;
    if (bus.ram_we) ram_mem[bus.ram_write_addr] <= bus.ram_data_in;
  end

  // Reference model: shadow memory, last-winner per port, queue of expected returns.
  typedef struct {
    int                due;
    logic              id;
    logic [DATA_W-1:0] data;
  } rd_exp_t;
  rd_exp_t           pend[$];
  rd_exp_t           ent;
  logic [DATA_W-1:0] ref_mem [64];
  logic              ref_wlast, ref_rlast;
  logic [1:0]        exp_wgnt, exp_rgnt, exp_v, wg, rg;
  logic [ADDR_W-1:0] exp_waddr, exp_raddr, wa, ra;
  logic [DATA_W-1:0] exp_wdata, exp_d;

  function automatic logic [1:0] winner(input logic [1:0] req, input logic last);
    if (req == 2'b00) return 2'b00;
    if (req == 2'b11) return 2'b01 << (!last);
    return req;
  endfunction

  always @(negedge clk) begin
    exp_v = 2'b00;
    exp_d = '0;
    if (rst) pend.delete();
    else if (pend.size() > 0 && pend[0].due == cyc) begin
      ent   = pend.pop_front();
      exp_v = 2'b01 << ent.id;
      exp_d = ent.data;
    end
    checks++;
    if (bus.rd_valid !== exp_v) begin
      errors++;
      $display("FAIL sb_rd_valid cyc=%0d: got %b want %b", cyc, bus.rd_valid, exp_v);
    end
    if (exp_v != 2'b00) begin
      checks++;
      if (bus.rd_data !== exp_d) begin
        errors++;
        $display("FAIL sb_rd_data cyc=%0d: got %h want %h", cyc, bus.rd_data, exp_d);
      end
    end
    if (rst) begin
      ref_wlast = 1'b1;
      ref_rlast = 1'b1;
      exp_wgnt  = 2'b00;
      exp_rgnt  = 2'b00;
    end else begin
      wg = winner(bus.wr_req, ref_wlast);
      rg = winner(bus.rd_req, ref_rlast);
      wa = wg[1] ? bus.wr_addr1 : bus.wr_addr0;
      ra = rg[1] ? bus.rd_addr1 : bus.rd_addr0;
`ifdef RAM_ARB_RAW_STALL_EN
      if (wg != 2'b00 && rg != 2'b00 && wa == ra) rg = 2'b00;
`endif
      if (rg != 2'b00) begin
        pend.push_back('{due: cyc + RD_LAT, id: rg[1], data: ref_mem[ra]});
        ref_rlast = rg[1];
      end
      exp_wdata = wg[1] ? bus.wr_data1 : bus.wr_data0;
      if (wg != 2'b00) begin
        ref_mem[wa] = exp_wdata;
        ref_wlast   = wg[1];
      end
      exp_wgnt  = wg;
      exp_rgnt  = rg;
      exp_waddr = wa;
      exp_raddr = ra;
    end
  end

  task automatic drive(input logic [1:0] wq, input logic [ADDR_W-1:0] wa0, input logic [ADDR_W-1:0] wa1,
                       input logic [DATA_W-1:0] wd0, input logic [DATA_W-1:0] wd1,
                       input logic [1:0] rq, input logic [ADDR_W-1:0] ra0, input logic [ADDR_W-1:0] ra1);
    @(posedge clk);
    #1;
    bus.wr_req   = wq;
    bus.wr_addr0 = wa0;
    bus.wr_addr1 = wa1;
    bus.wr_data0 = wd0;
    bus.wr_data1 = wd1;
    bus.rd_req   = rq;
    bus.rd_addr0 = ra0;
    bus.rd_addr1 = ra1;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 6'd1, 6'd2, 8'h01, 8'h02, 2'b11, 6'd3, 6'd4);
      checks++;
      if (bus.wr_gnt !== 2'b00 || bus.rd_gnt !== 2'b00 || bus.ram_we !== 1'b0 || bus.rd_valid !== 2'b00) begin
        errors++;
        $display("FAIL reset_outputs: got wr_gnt=%b rd_gnt=%b ram_we=%b rd_valid=%b want all 0",
                 bus.wr_gnt, bus.rd_gnt, bus.ram_we, bus.rd_valid);
      end
    end
    @(posedge clk);
    #1;
    bus.wr_req = 2'b00;
    bus.rd_req = 2'b00;
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    drive(2'b01, 6'd5, 6'd0, 8'hA5, 8'h00, 2'b00, 6'd0, 6'd0);
    checks++;
    if (bus.wr_gnt !== 2'b01 || bus.ram_we !== 1'b1 || bus.ram_write_addr !== 6'd5 || bus.ram_data_in !== 8'hA5) begin
      errors++;
      $display("FAIL single_write: got gnt=%b we=%b addr=%0d data=%h want 01 1 5 a5",
               bus.wr_gnt, bus.ram_we, bus.ram_write_addr, bus.ram_data_in);
    end
    drive(2'b01, 6'd9, 6'd0, 8'h11, 8'h00, 2'b00, 6'd0, 6'd0);
    drive(2'b10, 6'd0, 6'd6, 8'h00, 8'h3C, 2'b00, 6'd0, 6'd0);
    checks++;
    if (bus.wr_gnt !== 2'b10 || bus.ram_write_addr !== 6'd6 || bus.ram_data_in !== 8'h3C) begin
      errors++;
      $display("FAIL preload_req1: got gnt=%b addr=%0d data=%h want 10 6 3c",
               bus.wr_gnt, bus.ram_write_addr, bus.ram_data_in);
    end
  endtask

  task automatic test_write_rr();
    logic [1:0] want_g;
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 6'd1, 6'd2, 8'h40 + 8'(i), 8'h80 + 8'(i), 2'b00, 6'd0, 6'd0);
      want_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (bus.wr_gnt !== want_g || bus.ram_write_addr !== ((i % 2 == 0) ? 6'd1 : 6'd2) ||
          bus.ram_data_in !== ((i % 2 == 0) ? 8'h40 + 8'(i) : 8'h80 + 8'(i))) begin
        errors++;
        $display("FAIL write_rr[%0d]: got gnt=%b addr=%0d data=%h want gnt=%b", i,
                 bus.wr_gnt, bus.ram_write_addr, bus.ram_data_in, want_g);
      end
    end
  endtask

  task automatic test_read_rr();
    logic [1:0] want_g;
    for (int i = 0; i < 6; i++) begin
      drive(2'b00, 6'd0, 6'd0, 8'h00, 8'h00, (i < 4) ? 2'b11 : 2'b00, 6'd5, 6'd6);
      want_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      if (i < 4) begin
        checks++;
        if (bus.rd_gnt !== want_g || bus.ram_read_addr !== ((i % 2 == 0) ? 6'd5 : 6'd6)) begin
          errors++;
          $display("FAIL read_rr_gnt[%0d]: got gnt=%b addr=%0d want gnt=%b", i, bus.rd_gnt, bus.ram_read_addr, want_g);
        end
      end else begin
        checks++;
        if (bus.rd_gnt !== 2'b00 || bus.ram_read_addr !== 6'd6) begin
          errors++;
          $display("FAIL read_addr_hold[%0d]: got gnt=%b addr=%0d want 00 6", i, bus.rd_gnt, bus.ram_read_addr);
        end
      end
      checks++;
      if (i < 2) begin
        if (bus.rd_valid !== 2'b00) begin
          errors++;
          $display("FAIL read_rr_early[%0d]: got rd_valid=%b want 00", i, bus.rd_valid);
        end
      end else if (bus.rd_valid !== ((i % 2 == 0) ? 2'b01 : 2'b10) ||
                   bus.rd_data !== ((i % 2 == 0) ? 8'hA5 : 8'h3C)) begin
        errors++;
        $display("FAIL read_rr_data[%0d]: got rd_valid=%b rd_data=%h", i, bus.rd_valid, bus.rd_data);
      end
    end
  endtask

  task automatic test_raw_collision();
    drive(2'b01, 6'd9, 6'd0, 8'h77, 8'h00, 2'b01, 6'd9, 6'd0);
`ifdef RAM_ARB_RAW_STALL_EN
    checks++;
    if (bus.rd_gnt !== 2'b00 || bus.wr_gnt !== 2'b01) begin
      errors++;
      $display("FAIL raw_stall: got rd_gnt=%b wr_gnt=%b want 00 01", bus.rd_gnt, bus.wr_gnt);
    end
    drive(2'b00, 6'd0, 6'd0, 8'h00, 8'h00, 2'b01, 6'd9, 6'd0);
`endif
    checks++;
    if (bus.rd_gnt !== 2'b01) begin
      errors++;
      $display("FAIL raw_gnt: got rd_gnt=%b want 01", bus.rd_gnt);
    end
    drive(2'b00, 6'd0, 6'd0, 8'h00, 8'h00, 2'b00, 6'd0, 6'd0);
    drive(2'b00, 6'd0, 6'd0, 8'h00, 8'h00, 2'b00, 6'd0, 6'd0);
    checks++;
`ifdef RAM_ARB_RAW_STALL_EN
    if (bus.rd_valid !== 2'b01 || bus.rd_data !== 8'h77) begin
`else
    if (bus.rd_valid !== 2'b01 || bus.rd_data !== 8'h11) begin
`endif
      errors++;
      $display("FAIL raw_data: got rd_valid=%b rd_data=%h", bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_reset_inflight();
    drive(2'b00, 6'd0, 6'd0, 8'h00, 8'h00, 2'b01, 6'd5, 6'd0);
    checks++;
    if (bus.rd_gnt !== 2'b01) begin
      errors++;
      $display("FAIL inflight_gnt: got %b want 01", bus.rd_gnt);
    end
    @(posedge clk);
    #1;
    bus.rd_req = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.rd_valid !== 2'b00) begin
        errors++;
        $display("FAIL inflight_dropped[%0d]: got rd_valid=%b want 00", i, bus.rd_valid);
      end
      @(posedge clk);
    end
    drive(2'b11, 6'd20, 6'd21, 8'hC0, 8'hC1, 2'b11, 6'd5, 6'd6);
    checks++;
    if (bus.wr_gnt !== 2'b01 || bus.rd_gnt !== 2'b01) begin
      errors++;
      $display("FAIL post_reset_ptr: got wr_gnt=%b rd_gnt=%b want 01 01", bus.wr_gnt, bus.rd_gnt);
    end
  endtask

  task automatic test_idle_fairness();
    drive(2'b11, 6'd22, 6'd23, 8'hD0, 8'hD1, 2'b11, 6'd5, 6'd6);
    checks++;
    if (bus.wr_gnt !== 2'b10 || bus.rd_gnt !== 2'b10) begin
      errors++;
      $display("FAIL idle_pre: got wr_gnt=%b rd_gnt=%b want 10 10", bus.wr_gnt, bus.rd_gnt);
    end
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 6'd0, 6'd0, 8'h00, 8'h00, 2'b00, 6'd0, 6'd0);
      checks++;
      if (bus.wr_gnt !== 2'b00 || bus.rd_gnt !== 2'b00 || bus.ram_we !== 1'b0) begin
        errors++;
        $display("FAIL idle_gap[%0d]: got wr_gnt=%b rd_gnt=%b we=%b want 00 00 0", i, bus.wr_gnt, bus.rd_gnt, bus.ram_we);
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(2'b11, 6'd24, 6'd25, 8'hE0, 8'hE1, 2'b11, 6'd5, 6'd6);
      checks++;
      if (bus.wr_gnt !== ((i == 0) ? 2'b01 : 2'b10) || bus.rd_gnt !== ((i == 0) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL idle_resume[%0d]: got wr_gnt=%b rd_gnt=%b", i, bus.wr_gnt, bus.rd_gnt);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(2'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
            8'($urandom), 8'($urandom),
            2'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)));
      checks++;
      if (bus.wr_gnt !== exp_wgnt || bus.rd_gnt !== exp_rgnt || bus.ram_we !== (|exp_wgnt)) begin
        errors++;
        $display("FAIL rand_gnt[%0d]: got wr_gnt=%b rd_gnt=%b we=%b want %b %b %b", i,
                 bus.wr_gnt, bus.rd_gnt, bus.ram_we, exp_wgnt, exp_rgnt, |exp_wgnt);
      end
      if (exp_wgnt != 2'b00) begin
        checks++;
        if (bus.ram_write_addr !== exp_waddr || bus.ram_data_in !== exp_wdata) begin
          errors++;
          $display("FAIL rand_wr_bus[%0d]: got addr=%0d data=%h want %0d %h", i,
                   bus.ram_write_addr, bus.ram_data_in, exp_waddr, exp_wdata);
        end
      end
      if (exp_rgnt != 2'b00) begin
        checks++;
        if (bus.ram_read_addr !== exp_raddr) begin
          errors++;
          $display("FAIL rand_rd_addr[%0d]: got %0d want %0d", i, bus.ram_read_addr, exp_raddr);
        end
      end
    end
    for (int i = 0; i < 4; i++) drive(2'b00, 6'd0, 6'd0, 8'h00, 8'h00, 2'b00, 6'd0, 6'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    ram_pipe         = '0;
    bus.ram_data_out = '0;
    bus.wr_req = 2'b00;
    bus.rd_req = 2'b00;
    bus.wr_addr0 = '0;
    bus.wr_addr1 = '0;
    bus.wr_data0 = '0;
    bus.wr_data1 = '0;
    bus.rd_addr0 = '0;
    bus.rd_addr1 = '0;
    test_reset();
    test_single_write();
    test_write_rr();
    test_read_rr();
    test_raw_collision();
    test_reset_inflight();
    test_idle_fairness();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_dp_arbiter.md
Name: ram_dp_arbiter

Overview:
- Shares one 64x8 dual-port RAM (one write port, one registered-address read port, 2-cycle read latency) between two write requesters and two read requesters.
- Arbitrates write and read ports independently, round-robin.
- Tracks in-flight reads so returned data is tagged to the requester that issued it.
- Sits between client logic and the RAM; the RAM itself is external.

Parameters:
- DATA_W, 8, RAM word width
- ADDR_W, 6, RAM address width
- RD_LAT, 2, RAM read latency in cycles (read address accepted -> data_out valid)

Ports:
- clk  in  1  single clock for arbiter and RAM (RAM read_clk = write_clk = clk)
- rst  in  1  asynchronous, active-high reset
- wr_req  in  2  write request per requester; held until granted
- wr_addr0, wr_addr1  in  ADDR_W  write address, requester 0/1
- wr_data0, wr_data1  in  DATA_W  write data, requester 0/1
- wr_gnt  out  2  one-hot write grant; combinational, same cycle as request
- rd_req  in  2  read request per requester; held until granted
- rd_addr0, rd_addr1  in  ADDR_W  read address, requester 0/1
- rd_gnt  out  2  one-hot read grant; combinational
- rd_data  out  DATA_W  read data, pass-through of ram_data_out
- rd_valid  out  2  one-hot; rd_data belongs to requester i
- ram_we  out  1  RAM write enable
- ram_write_addr  out  ADDR_W  RAM write address
- ram_data_in  out  DATA_W  RAM write data
- ram_read_addr  out  ADDR_W  RAM read address
- ram_data_out  in  DATA_W  RAM read data

Behaviour:

Reset:
- While rst is high, wr_gnt, rd_gnt, rd_valid and ram_we are 0.
- Round-robin pointers wr_last and rd_last reset to 1, so requester 0 wins first.
- Tag pipeline is cleared; in-flight reads are dropped and no rd_valid fires after reset release.

Write arbitration, evaluated every cycle:
- If only one wr_req is set, that requester is granted.
- If both are set, grant the requester != wr_last.
- A grant sets wr_last to the granted index at the posedge.
- ram_we = |wr_gnt; ram_write_addr and ram_data_in are muxed from the granted requester.
- With no grant, the mux selects requester 0 data but ram_we = 0.

Read arbitration:
- Same round-robin rule, with its own pointer rd_last.
- ram_read_addr is muxed from the granted requester.
- With no grant, ram_read_addr holds its previous registered value, so the RAM address is stable.

Tag pipeline:
- RD_LAT stages of {valid, id}; stage 0 loads {|rd_gnt, granted id} at each posedge.
- rd_valid[id] = last stage valid decoded.
- rd_valid rises exactly RD_LAT cycles after the rd_gnt cycle.
- Back-to-back reads every cycle are supported: throughput 1 read and 1 write per cycle.

Data and hazards:
- rd_data = ram_data_out, no extra register; it is meaningful only while a rd_valid bit is set.
- A write and a read to the same address in the same cycle both proceed (without RAW_STALL_EN); the read returns pre-write data (RAM read-old behaviour).
- Requests deasserted before grant are simply lost; no state is kept.
- Pointers change only on a grant, so an idle cycle does not disturb fairness.
- Fairness bound: a held request waits at most 1 cycle.

Optional Feature:
- Macro: RAM_ARB_RAW_STALL_EN.
- Defined:
  - If the read requester that would be granted has the same address as the write granted in the same cycle, its rd_gnt is withheld that cycle and rd_last is unchanged.
  - The read is granted the next cycle and returns post-write data.
  - Stall is at most 1 cycle per collision.
  - The other read requester is not granted in the stall cycle (port idles), keeping order simple.
- Undefined: no comparison; a colliding read returns old data as above.

Test Plan:
- Reset release, wr_req=01, wr_addr0=5, wr_data0=8'hA5 -> wr_gnt=01 same cycle, ram_we=1, ram_write_addr=5, ram_data_in=8'hA5.
- wr_req=11 held 4 cycles, addrs 1/2 -> wr_gnt sequence 01,10,01,10, four RAM writes in order.
- rd_req=11 held 4 cycles, addrs 5/6 preloaded with A5/3C -> rd_gnt 01,10,01,10; rd_valid 01,10,01,10 starting 2 cycles after the first grant; rd_data A5,3C,A5,3C.
- Same-cycle write 8'h77 to addr 9 and read addr 9 (old 8'h11) -> without macro: rd_data=11 after 2 cycles. With RAM_ARB_RAW_STALL_EN: rd_gnt delayed 1 cycle, rd_data=77.
- Read granted, then rst pulsed 1 cycle before data return -> rd_valid stays 00; after release, wr_last/rd_last=1 and the next dual request grants requester 0.
- wr_req and rd_req idle 3 cycles between grants -> pointers unchanged, alternation resumes correctly.
